// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse generator.
// Holds the channel state encoding and the edge selection codes.
package pulse_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   localparam logic [1:0] EDGE_RISE = 2'b00;
   localparam logic [1:0] EDGE_FALL = 2'b01;
   localparam logic [1:0] EDGE_BOTH = 2'b10;
   localparam logic [1:0] EDGE_NONE = 2'b11;

   function automatic logic edge_hit(
      input logic [1:0] sel,
      input logic       cur,
      input logic       prev
   );
      logic hit;
      case (sel)
         EDGE_RISE: hit = cur & ~prev;
         EDGE_FALL: hit = ~cur & prev;
         EDGE_BOTH: hit = cur ^ prev;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse generator channel: edge detect, IDLE/PULSE/HOLDOFF FSM, overrun.
// PULSE_GEN_SYNC_EN adds a 2-flop input synchroniser ahead of edge detect.
module pulse_gen_chan #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig,
   input  logic [1:0]       edge_sel,
   input  logic [CNT_W-1:0] pulse_len,
   input  logic [CNT_W-1:0] holdoff_len,
   input  logic             retrig,
   input  logic             clr_overrun,
   output logic             pulse_out,
   output logic             busy,
   output logic             overrun
);
   import pulse_gen_pkg::*;

   localparam logic [CNT_W-1:0] ONE = 1;

   logic             cur;
   logic             in_d;
   logic [1:0]       pcnt;
   logic             ev;
   logic             drop;
   logic             ovr;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len_m1;
   logic [CNT_W-1:0] hold_m1;
   state_t           state;

`ifdef PULSE_GEN_SYNC_EN
   localparam logic [1:0] PRIME_N = 2'd3;
   logic [1:0] sync_q;

   // two-stage synchroniser for the asynchronous input bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], sig};
   end

   assign cur = sync_q[1];
`else
   localparam logic [1:0] PRIME_N = 2'd1;

   assign cur = sig;
`endif

   // previous input sample and startup priming counter, run even when disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_d <= 1'b0;
         pcnt <= 2'd0;
      end else begin
         in_d <= cur;
         if (pcnt != PRIME_N) pcnt <= pcnt + 2'd1;
      end
   end

   assign ev      = (pcnt == PRIME_N) & edge_hit(edge_sel, cur, in_d);
   assign len_m1  = (pulse_len == '0) ? '0 : pulse_len - ONE;
   assign hold_m1 = holdoff_len - ONE;

   // an event is lost when the channel is busy and cannot reload
   always_comb begin
      drop = 1'b0;
      if (en && ev) begin
         case (state)
            ST_PULSE:   drop = ~retrig;
            ST_HOLDOFF: drop = 1'b1;
            default:    drop = 1'b0;
         endcase
      end
   end

   // channel state machine and shared pulse/hold-off counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (!en) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (ev) begin
                  state <= ST_PULSE;
                  cnt   <= len_m1;
               end
            end
            ST_PULSE: begin
               if (ev && retrig) begin
                  cnt <= len_m1;
               end else if (cnt != '0) begin
                  cnt <= cnt - ONE;
               end else if (holdoff_len != '0) begin
                  state <= ST_HOLDOFF;
                  cnt   <= hold_m1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_HOLDOFF: begin
               if (cnt != '0) cnt <= cnt - ONE;
               else           state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // sticky overrun; a new drop beats a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovr <= 1'b0;
      else        ovr <= drop | (ovr & ~clr_overrun);
   end

   assign pulse_out = (state == ST_PULSE);
   assign busy      = (state != ST_IDLE);
   assign overrun   = ovr;

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator top: NUM_CH independent channels, shared config.
// Optional macro PULSE_GEN_SYNC_EN enables per-bit input synchronisers.
module pulse_gen_multi #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [NUM_CH-1:0] in,
   input  logic [1:0]        edge_sel,
   input  logic [CNT_W-1:0]  pulse_len,
   input  logic [CNT_W-1:0]  holdoff_len,
   input  logic              retrig,
   input  logic              clr_overrun,
   output logic [NUM_CH-1:0] pulse_out,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] overrun
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pulse_gen_chan #(
         .CNT_W(CNT_W)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .en          (en),
         .sig         (in[i]),
         .edge_sel    (edge_sel),
         .pulse_len   (pulse_len),
         .holdoff_len (holdoff_len),
         .retrig      (retrig),
         .clr_overrun (clr_overrun),
         .pulse_out   (pulse_out[i]),
         .busy        (busy[i]),
         .overrun     (overrun[i])
      );
   end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Testbench for pulse_gen_multi: directed vector tables, reset sequences,
// and randomized traffic against a timeline-based reference model.
module tb_pulse_gen_multi;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
`ifdef PULSE_GEN_SYNC_EN
   localparam int LAT   = 2;
   localparam int PRIME = 3;
   localparam bit SYNC  = 1'b1;
`else
   localparam int LAT   = 0;
   localparam int PRIME = 1;
   localparam bit SYNC  = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic [NUM_CH-1:0] in = '0;
   logic [1:0]        edge_sel = 2'b00;
   logic [CNT_W-1:0]  pulse_len = '0;
   logic [CNT_W-1:0]  holdoff_len = '0;
   logic              retrig = 1'b0;
   logic              clr_overrun = 1'b0;
   logic [NUM_CH-1:0] pulse_out;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] overrun;

   pulse_gen_multi #(
      .NUM_CH(NUM_CH),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .in          (in),
      .edge_sel    (edge_sel),
      .pulse_len   (pulse_len),
      .holdoff_len (holdoff_len),
      .retrig      (retrig),
      .clr_overrun (clr_overrun),
      .pulse_out   (pulse_out),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: each channel is a pair of timeline marks.
   // pl = last edge index with pulse high, bl = last edge index busy.
   int                t_m;
   int                since_rst;
   int                pl [NUM_CH];
   int                bl [NUM_CH];
   logic [NUM_CH-1:0] ov_m, exp_p, exp_b;
   logic [NUM_CH-1:0] h1, h2, h3;

   function automatic logic hit(input logic [1:0] s, input logic c,
                                input logic p);
      if (s == 2'b00) return c && !p;
      if (s == 2'b01) return !c && p;
      if (s == 2'b10) return c != p;
      return 1'b0;
   endfunction

   task automatic model_reset();
      t_m = 0;
      since_rst = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         pl[c] = -100;
         bl[c] = -100;
      end
      ov_m = '0; exp_p = '0; exp_b = '0;
      h1 = '0; h2 = '0; h3 = '0;
   endtask

   task automatic model_step();
      logic [NUM_CH-1:0] cur, prev;
      int   eff;
      logic ev, drop;
      cur  = SYNC ? h2 : in;
      prev = SYNC ? h3 : h1;
      eff  = (pulse_len == 0) ? 1 : int'(pulse_len);
      for (int c = 0; c < NUM_CH; c++) begin
         ev   = (since_rst >= PRIME) && hit(edge_sel, cur[c], prev[c]);
         drop = 1'b0;
         if (!en) begin
            pl[c] = t_m - 1;
            bl[c] = t_m - 1;
         end else if (ev) begin
            if ((t_m - 1 > bl[c]) || ((t_m - 1 <= pl[c]) && retrig)) begin
               pl[c] = t_m + eff - 1;
               bl[c] = pl[c] + int'(holdoff_len);
            end else begin
               drop = 1'b1;
            end
         end
         ov_m[c]  = drop | (ov_m[c] & ~clr_overrun);
         exp_p[c] = (t_m <= pl[c]);
         exp_b[c] = (t_m <= bl[c]);
      end
      h3 = h2; h2 = h1; h1 = in;
      since_rst++;
      t_m++;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check(input string name, input logic [NUM_CH-1:0] act,
                        input logic [NUM_CH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", name, act, exp);
      end
   endtask

   typedef struct {
      logic [NUM_CH-1:0] in;
      logic              en;
      logic              clr;
      logic [NUM_CH-1:0] p;
      logic [NUM_CH-1:0] b;
      logic [NUM_CH-1:0] o;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [3:0] i, input logic e, input logic c,
                      input logic [3:0] p, input logic [3:0] b,
                      input logic [3:0] o);
      vec_t v;
      v.in = i; v.en = e; v.clr = c; v.p = p; v.b = b; v.o = o;
      vq.push_back(v);
   endtask

   // Row 0 of every table is idle with a stable input, so the first LAT
   // steps of a synchronised build expect row 0's outputs.
   task automatic run_vecs(input string name, input logic [1:0] es,
                           input int pln, input int hln, input logic rt);
      int n, ri, ei;
      edge_sel    = es;
      pulse_len   = CNT_W'(pln);
      holdoff_len = CNT_W'(hln);
      retrig      = rt;
      en          = 1'b0;
      clr_overrun = 1'b1;
      in          = vq[0].in;
      repeat (4) cycle();
      n = vq.size();
      for (int i = 0; i < n + LAT; i++) begin
         ri = (i < n) ? i : n - 1;
         ei = (i < LAT) ? 0 : i - LAT;
         in          = vq[ri].in;
         en          = vq[ei].en;
         clr_overrun = vq[ei].clr;
         cycle();
         check($sformatf("%s[%0d].pulse", name, ei), pulse_out, vq[ei].p);
         check($sformatf("%s[%0d].busy", name, ei), busy, vq[ei].b);
         check($sformatf("%s[%0d].ovr", name, ei), overrun, vq[ei].o);
      end
      vq.delete();
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst.pulse", pulse_out, '0);
      check("rst.busy", busy, '0);
      check("rst.ovr", overrun, '0);
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NUM_CH-1:0] m;
      model_reset();
      hold_reset();

      // rising edge, 3-cycle pulse
      add(4'h0,1,0, 4'h0,4'h0,4'h0);
      add(4'h1,1,0, 4'h1,4'h1,4'h0);
      add(4'h1,1,0, 4'h1,4'h1,4'h0);
      add(4'h1,1,0, 4'h1,4'h1,4'h0);
      add(4'h1,1,0, 4'h0,4'h0,4'h0);
      add(4'h1,1,0, 4'h0,4'h0,4'h0);
      run_vecs("rise", 2'b00, 3, 0, 1'b0);

      // zero length, falling edge only
      add(4'h2,1,0, 4'h0,4'h0,4'h0);
      add(4'h0,1,0, 4'h2,4'h2,4'h0);
      add(4'h0,1,0, 4'h0,4'h0,4'h0);
      add(4'h2,1,0, 4'h0,4'h0,4'h0);
      add(4'h2,1,0, 4'h0,4'h0,4'h0);
      run_vecs("fall0", 2'b01, 0, 0, 1'b0);

      // hold-off drops an edge, later edge accepted
      add(4'h0,1,0, 4'h0,4'h0,4'h0);
      add(4'h1,1,0, 4'h1,4'h1,4'h0);
      add(4'h0,1,0, 4'h1,4'h1,4'h0);
      add(4'h0,1,0, 4'h0,4'h1,4'h0);
      add(4'h1,1,0, 4'h0,4'h1,4'h1);
      add(4'h0,1,0, 4'h0,4'h1,4'h1);
      add(4'h0,1,0, 4'h0,4'h1,4'h1);
      add(4'h0,1,0, 4'h0,4'h0,4'h1);
      add(4'h1,1,0, 4'h1,4'h1,4'h1);
      add(4'h1,1,0, 4'h1,4'h1,4'h1);
      add(4'h1,1,0, 4'h0,4'h1,4'h1);
      add(4'h1,1,0, 4'h0,4'h1,4'h1);
      add(4'h1,1,0, 4'h0,4'h1,4'h1);
      add(4'h1,1,0, 4'h0,4'h1,4'h1);
      add(4'h1,1,0, 4'h0,4'h0,4'h1);
      run_vecs("holdoff", 2'b00, 2, 4, 1'b0);

      // both edges, retrigger extends to 6 cycles
      add(4'h0,1,0, 4'h0,4'h0,4'h0);
      add(4'h4,1,0, 4'h4,4'h4,4'h0);
      add(4'h4,1,0, 4'h4,4'h4,4'h0);
      add(4'h0,1,0, 4'h4,4'h4,4'h0);
      add(4'h0,1,0, 4'h4,4'h4,4'h0);
      add(4'h0,1,0, 4'h4,4'h4,4'h0);
      add(4'h0,1,0, 4'h4,4'h4,4'h0);
      add(4'h0,1,0, 4'h0,4'h0,4'h0);
      run_vecs("retrig1", 2'b10, 4, 0, 1'b1);

      // same stimulus without retrigger
      add(4'h0,1,0, 4'h0,4'h0,4'h0);
      add(4'h4,1,0, 4'h4,4'h4,4'h0);
      add(4'h4,1,0, 4'h4,4'h4,4'h0);
      add(4'h0,1,0, 4'h4,4'h4,4'h4);
      add(4'h0,1,0, 4'h4,4'h4,4'h4);
      add(4'h0,1,0, 4'h0,4'h0,4'h4);
      add(4'h0,1,0, 4'h0,4'h0,4'h4);
      run_vecs("retrig0", 2'b10, 4, 0, 1'b0);

      // enable drop mid-pulse, clear racing a new overrun
      add(4'h0,1,0, 4'h0,4'h0,4'h0);
      add(4'h1,1,0, 4'h1,4'h1,4'h0);
      add(4'h1,1,0, 4'h1,4'h1,4'h0);
      add(4'h1,0,0, 4'h0,4'h0,4'h0);
      add(4'h1,1,0, 4'h0,4'h0,4'h0);
      add(4'h0,1,0, 4'h0,4'h0,4'h0);
      add(4'h1,1,0, 4'h1,4'h1,4'h0);
      add(4'h0,1,0, 4'h1,4'h1,4'h0);
      add(4'h1,1,1, 4'h1,4'h1,4'h1);
      add(4'h1,1,0, 4'h1,4'h1,4'h1);
      add(4'h1,1,0, 4'h1,4'h1,4'h1);
      add(4'h1,1,0, 4'h0,4'h0,4'h1);
      add(4'h1,0,0, 4'h0,4'h0,4'h1);
      add(4'h1,1,1, 4'h0,4'h0,4'h0);
      run_vecs("enclr", 2'b00, 5, 0, 1'b0);

      // input held high through reset release: no pulse
      edge_sel = 2'b00; pulse_len = 3; holdoff_len = 0;
      retrig = 1'b0; clr_overrun = 1'b0; en = 1'b1;
      in = 4'hF;
      hold_reset();
      for (int i = 0; i < 6; i++) begin
         cycle();
         check($sformatf("rsthold[%0d].pulse", i), pulse_out, 4'h0);
         check($sformatf("rsthold[%0d].busy", i), busy, 4'h0);
      end

      // asynchronous reset in the middle of a pulse
      in = 4'h0;
      repeat (4) cycle();
      in = 4'h1;
      repeat (LAT + 1) cycle();
      check("midrst.pre", pulse_out, 4'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.pulse", pulse_out, 4'h0);
      check("midrst.busy", busy, 4'h0);
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;

      // randomized phases against the model; config changes with en low
      for (int ph = 0; ph < 25; ph++) begin
         edge_sel    = 2'($urandom_range(3, 0));
         pulse_len   = CNT_W'($urandom_range(6, 0));
         holdoff_len = CNT_W'($urandom_range(5, 0));
         retrig      = 1'($urandom_range(1, 0));
         en          = 1'b0;
         clr_overrun = 1'b0;
         cycle();
         for (int k = 0; k < 60; k++) begin
            m  = NUM_CH'($urandom & $urandom);
            in = in ^ m;
            en = ($urandom_range(39, 0) != 0);
            clr_overrun = ($urandom_range(15, 0) == 0);
            cycle();
            check("rnd.pulse", pulse_out, exp_p);
            check("rnd.busy", busy, exp_b);
            check("rnd.ovr", overrun, ov_m);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_gen_multi.md
Name: pulse_gen_multi

Overview:
- Multi-channel, parametrised pulse generator, successor to the single-bit 0→1 sequence detector.
- Per channel: detect a selectable edge on an input bit, then emit a fixed-length output pulse of programmable length, followed by an optional hold-off window.
- Supports retrigger/extend mode and a sticky overrun flag for events that arrive while a channel is busy.
- Sits between raw status/strobe inputs and downstream control logic that needs clean, width-controlled pulses.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 8, width of pulse and hold-off length counters.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous, active-low reset; clears all state immediately.
- en  in  1  global enable; 0 forces all channels to IDLE.
- in  in  NUM_CH  raw input bits, one per channel.
- edge_sel  in  2  00 rising, 01 falling, 10 both, 11 none (detection off).
- pulse_len  in  CNT_W  pulse length in cycles; 0 treated as 1.
- holdoff_len  in  CNT_W  hold-off length in cycles after a pulse; 0 means no hold-off.
- retrig  in  1  1 means an event during PULSE reloads the counter.
- clr_overrun  in  1  clears all overrun flags.
- pulse_out  out  NUM_CH  registered output pulses.
- busy  out  NUM_CH  channel is in PULSE or HOLDOFF.
- overrun  out  NUM_CH  sticky flag: an event was dropped.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - pulse_out=0, busy=0, overrun=0.
  - All states IDLE, counters 0, in_d=0, primed=0.
- Edge detection:
  - in_d registers in every cycle, including while en=0.
  - primed=0 on the first cycle after reset release: no event is generated that cycle. primed goes to 1 after that cycle.
  - Event = primed & edge_sel match on (in, in_d).
- Per-channel FSM, states IDLE, PULSE, HOLDOFF:
  - IDLE + event → PULSE; cnt loads eff_len−1, where eff_len = max(pulse_len, 1).
  - PULSE, cnt>0 → cnt decrements.
  - PULSE + event + retrig=1 → cnt reloads eff_len−1; the pulse is extended with no gap.
  - PULSE + event + retrig=0 → event dropped, overrun set.
  - PULSE, cnt=0, no reload:
    - holdoff_len≠0 → HOLDOFF, cnt loads holdoff_len−1.
    - otherwise → IDLE.
  - HOLDOFF + event → event dropped, overrun set.
  - HOLDOFF, cnt=0 → IDLE.
  - An event in the last HOLDOFF cycle is still dropped; events are accepted from state IDLE only.
- Outputs:
  - pulse_out = (state==PULSE), registered.
  - busy = (state != IDLE).
- Latency:
  - Input changes before posedge k → pulse_out high after posedge k.
  - Pulse stays high exactly eff_len cycles and falls after posedge k+eff_len.
- Config changes (pulse_len, holdoff_len, edge_sel) take effect at the next counter load or event evaluation. A running count is not disturbed.
- en=0 (synchronous): all channels go to IDLE with cnt=0 on the next edge, pulse_out falls, and events are ignored. Overrun is held.
- clr_overrun with a simultaneous new overrun event: set wins.
- Channels are fully independent.
- rst_n asserted mid-pulse: output drops immediately, asynchronously.

Optional Feature:
- Macro PULSE_GEN_SYNC_EN.
- Defined:
  - Each in bit passes through a 2-flop synchroniser (reset 0) before edge detection.
  - Latency grows by 2 cycles: pulse_out rises after posedge k+2.
  - primed suppresses events for the first 3 cycles after reset release.
- Undefined:
  - in feeds edge detection directly, with the latency stated above.

Decomposition:
- Package pulse_gen_pkg:
  - state enum (IDLE, PULSE, HOLDOFF).
  - edge_sel localparams EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE.
- Sub-module pulse_gen_chan:
  - Holds one channel's edge detect, FSM, counter and overrun flag.
  - Top instantiates NUM_CH copies in a generate loop, with shared config fanned out.

Test Plan:
- Rise, basic pulse: edge_sel=00, pulse_len=3, holdoff_len=0; in[0] 0→1 → pulse_out[0] high exactly 3 cycles starting 1 edge later, busy identical, other channels 0.
- Zero length plus falling edge: pulse_len=0, edge_sel=01; in[1] 1→0 → 1-cycle pulse. A 0→1 edge → no pulse.
- Hold-off drop: pulse_len=2, holdoff_len=4, retrig=0; second edge 3 cycles after the first (in HOLDOFF) → no new pulse, overrun[0]=1. An edge 7 cycles after the first → new pulse.
- Retrigger: pulse_len=4, retrig=1, edge_sel=10; toggle in[2] at cycles 0 and 2 → single continuous pulse of 6 cycles, overrun=0. Same stimulus with retrig=0 → 4-cycle pulse, overrun[2]=1.
- Enable and clear: drop en mid-pulse → pulse_out 0 next edge, busy 0. Assert clr_overrun in the same cycle as a new drop → overrun stays 1.
- Reset: in held 1 through rst_n release → no pulse. Assert rst_n mid-pulse → outputs 0 immediately without a clock edge. Rerun the first scenario with PULSE_GEN_SYNC_EN defined → rise is 2 cycles later.
